// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch queue.
package fetch_pkg;
  localparam int FQ_DEPTH_DEFAULT = 4;
  localparam int FQ_WIDTH_DEFAULT = 32;
  typedef logic [FQ_WIDTH_DEFAULT-1:0] instr_t;
  localparam instr_t NOP = 32'h0;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-to-decode handshake bundle; slave is the queue, master drives it.
interface fetch_queue_if #(parameter int WIDTH = 32, parameter int DEPTH = 4);
  logic push_valid;
  logic [WIDTH-1:0] push_instr;
  logic [WIDTH-1:0] push_pc;
  logic push_ready;
  logic pop_valid;
  logic [WIDTH-1:0] pop_instr;
  logic [WIDTH-1:0] pop_pc;
  logic pop_ready;
  logic flush;
  logic [$clog2(DEPTH+1)-1:0] count;
  modport slave (input push_valid, push_instr, push_pc, pop_ready, flush,
                 output push_ready, pop_valid, pop_instr, pop_pc, count);
  modport master (output push_valid, push_instr, push_pc, pop_ready, flush,
                  input push_ready, pop_valid, pop_instr, pop_pc, count);
endinterface

// File: rtl/fq_storage.sv
// fq_storage: entry array with one write port and an asynchronous read port; array is not reset.
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int DW = 64
) (
  input  logic clk,
  input  logic we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction/PC queue between fetch and decode with flush.
// Define FETCHQ_BYPASS_EN to let an empty queue hand a push straight to decode in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  parameter int WIDTH = FQ_WIDTH_DEFAULT
) (
  input logic Clk,
  input logic Rst,
  fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] head;
  logic bypass, do_push, do_pop;
  occ_t occ;
  always_comb occ = cnt == '0 ? EMPTY : cnt == CW'(DEPTH) ? FULL : PARTIAL;
`ifdef FETCHQ_BYPASS_EN
  assign bypass = occ == EMPTY && bus.push_valid && bus.pop_ready && !bus.flush;
`else
  assign bypass = 1'b0;
`endif
  assign bus.push_ready = occ != FULL;
  assign bus.pop_valid = occ != EMPTY || bypass;
  assign bus.pop_instr = occ != EMPTY ? head[2*WIDTH-1:WIDTH] : bypass ? bus.push_instr : WIDTH'(NOP);
  assign bus.pop_pc = occ != EMPTY ? head[WIDTH-1:0] : bypass ? bus.push_pc : '0;
  assign bus.count = cnt;
  // a bypassed entry goes straight to decode and is never written
  assign do_push = bus.push_valid && bus.push_ready && !bus.flush && !bypass;
  assign do_pop = occ != EMPTY && bus.pop_ready && !bus.flush;
  always_ff @(posedge Clk) begin
    if (Rst || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end
  fq_storage #(.DEPTH(DEPTH), .DW(2*WIDTH)) u_storage (
    .clk(Clk),
    .we(do_push && !Rst),
    .waddr(wr_ptr),
    .raddr(rd_ptr),
    .wdata({bus.push_instr, bus.push_pc}),
    .rdata(head)
  );
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered instruction entries (power of two, 2..16).
REQ-002 SHALL have parameter WIDTH, default 32, instruction and PC width in bits.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 SHALL have port Rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port push_valid  input  1  fetch stage offers an instruction.
REQ-006 SHALL have port push_instr  input  WIDTH  fetched instruction word.
REQ-007 SHALL have port push_pc  input  WIDTH  PC of the fetched instruction.
REQ-008 SHALL have port push_ready  output  1  queue can accept an entry this cycle.
REQ-009 SHALL have port pop_valid  output  1  head entry is presented to decode.
REQ-010 SHALL have port pop_instr  output  WIDTH  head instruction word.
REQ-011 SHALL have port pop_pc  output  WIDTH  head PC.
REQ-012 SHALL have port pop_ready  input  1  decode consumes the head (low = stall).
REQ-013 SHALL have port flush  input  1  branch/jump taken (PCSrc); discard all entries.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-015 Push SHALL occur when push_valid && push_ready; pop SHALL occur when pop_valid && pop_ready.
REQ-016 push_ready SHALL equal (count < DEPTH) and SHALL NOT depend on pop_ready.
REQ-017 pop_valid SHALL equal (count != 0); pop_instr/pop_pc SHALL be the head entry, taken directly from storage.
REQ-018 Without bypass, latency from accepted push to pop_valid SHALL be 1 cycle.
REQ-019 Occupancy states SHALL be EMPTY (count 0), PARTIAL, and FULL (count DEPTH), derived from count.
REQ-020 Transitions: push only -> count+1; pop only -> count-1; push and pop together -> count unchanged, head and tail both advance.
REQ-021 Read and write pointers SHALL be $clog2(DEPTH) bits and SHALL wrap modulo DEPTH without any extra cycle.
REQ-022 A push while FULL is impossible by REQ-016; a pop while EMPTY SHALL be ignored.
REQ-023 When flush is high, the next cycle SHALL have count=0 and both pointers at 0; a push or pop in the flush cycle SHALL be discarded.
REQ-024 When pop_valid is low, pop_instr SHALL read 0 (NOP), so decode sees a bubble.
REQ-025 Held entries SHALL remain unchanged while pop_ready is low (stall), for any number of cycles.

Reset
REQ-026 With Rst high at a posedge: count=0, pointers=0, pop_valid=0, pop_instr=0, pop_pc=0, push_ready=1.
REQ-027 Rst SHALL take priority over flush, push and pop; a reset mid-operation SHALL discard all entries.

Configuration
REQ-028 Macro FETCHQ_BYPASS_EN SHALL control the same-cycle bypass path.
REQ-029 With FETCHQ_BYPASS_EN defined: when count=0, push_valid=1, pop_ready=1 and flush=0, then in that same cycle:
- pop_valid SHALL be 1;
- pop_instr/pop_pc SHALL equal push_instr/push_pc;
- the entry SHALL NOT be stored, and count stays 0.
REQ-030 Without FETCHQ_BYPASS_EN, the pop outputs SHALL come only from storage, with the 1-cycle latency of REQ-018.

Structure
REQ-031 Package fetch_pkg SHALL hold:
- instr_t (WIDTH-bit);
- the NOP constant (32'h0);
- FQ_DEPTH_DEFAULT (4).
REQ-032 Storage SHALL be a sub-module fq_storage: DEPTH x 2*WIDTH array, one write port, one asynchronous read port, no reset on the array.
REQ-033 Pointer and count logic SHALL reside in fetch_queue.

Verification
REQ-034 Reset: assert Rst 2 cycles with push_valid=1 -> count=0, pop_valid=0, pop_instr=0, push_ready=1.
REQ-035 Fill/drain: pop_ready=0, push PC 0,4,8,12 -> count=4, push_ready=0. Then pop_ready=1 -> pop_pc 0,4,8,12 in order, then count=0.
REQ-036 Wrap: run continuous push+pop with count=2 for 10 cycles -> count stays 2, PCs in order, pointers wrap past 3.
REQ-037 Flush: with count=3, assert flush together with push PC 0x40 -> next cycle count=0, pop_valid=0, PC 0x40 absent.
REQ-038 Stall: hold pop_ready=0 for 5 cycles with count=1, head 0x8C130014 -> pop_instr constant, count=1.
REQ-039 Bypass: with FETCHQ_BYPASS_EN, empty queue, push 0x02328020 with pop_ready=1 -> pop_instr=0x02328020 in the same cycle, count=0. Without the macro -> visible the next cycle.
